ifetch: RTL and testbench

Instruction fetch unit that feeds the instruction queue: it holds the fetch PC and reads four bytes through the byte-wide memory-controller port. It assembles them little-endian into a 32-bit instruction and presents it with its PC under a valid/stop handshake. It sits between the memory controller (read port) and the instruction queue. On a PC redirect it discards in-flight work and restarts at the new address.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch_jal_imm.sv | 11 +
 rtl/ifetch.sv | 104 ++++++++++
 tb/tb_ifetch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants for the instruction fetch unit.
// Opcode, FSM state encodings and instruction width in bytes.
package ifetch_pkg;

    localparam logic [6:0] OPCODE_JAL = 7'b1101111;

    localparam logic [0:0] IF_FETCH = 1'b0;
    localparam logic [0:0] IF_HOLD  = 1'b1;

    localparam int         INSTR_BYTES = 4;
    localparam logic [2:0] ISSUE_LAST  = 3'(INSTR_BYTES);

endpackage

// File: rtl/ifetch_jal_imm.sv
// ifetch_jal_imm: J-type immediate extraction with sign extension.
// Ports: instr_hi = instruction bits [31:12]; imm = byte offset.
module ifetch_jal_imm (
    input  logic [31:12] instr_hi,
    output logic [31:0]  imm
);

    assign imm = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                  instr_hi[20], instr_hi[30:21], 1'b0};

endmodule

// File: rtl/ifetch.sv
// ifetch: byte-serial instruction fetch, little-endian assembly, valid/stop out.
// Ports: clk_in, rst_n_in (async low), rdy_in (global freeze),
//   pc_update/pc_address (redirect), stop (queue full),
//   mem_req/mem_addr/mem_grant/mem_din (byte read port),
//   instr_valid/instr_out/instr_pc (to instruction queue).
// Option: IFETCH_JAL_EN follows JAL targets when an instruction is accepted.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        pc_update,
    input  logic [31:0] pc_address,
    input  logic        stop,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
);

    logic [0:0]  state;
    logic [31:0] pc;
    logic [2:0]  issue_cnt;
    logic [1:0]  recv_cnt;
    logic        pend;
    logic [23:0] byte_buf;
    logic [31:0] next_pc;

    assign mem_req  = (state == IF_FETCH) && (issue_cnt < ISSUE_LAST) && rdy_in;
    assign mem_addr = pc + {29'b0, issue_cnt};

`ifdef IFETCH_JAL_EN
    logic [31:0] jal_imm;

    ifetch_jal_imm u_jal_imm (
        .instr_hi (instr_out[31:12]),
        .imm      (jal_imm)
    );

    assign next_pc = (instr_out[6:0] == OPCODE_JAL) ? instr_pc + jal_imm
                                                    : pc + 32'd4;
`else
    assign next_pc = pc + 32'd4;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IF_FETCH;
            pc          <= RESET_PC;
            issue_cnt   <= 3'd0;
            recv_cnt    <= 2'd0;
            pend        <= 1'b0;
            byte_buf    <= 24'd0;
            instr_valid <= 1'b0;
            instr_out   <= 32'd0;
            instr_pc    <= 32'd0;
        end else if (rdy_in) begin
            if (pc_update) begin
                // Clearing pend drops the byte still in flight from the old stream.
                pc          <= pc_address;
                state       <= IF_FETCH;
                issue_cnt   <= 3'd0;
                recv_cnt    <= 2'd0;
                pend        <= 1'b0;
                instr_valid <= 1'b0;
            end else if (state == IF_FETCH) begin
                if (mem_req && mem_grant) begin
                    issue_cnt <= issue_cnt + 3'd1;
                    pend      <= 1'b1;
                end else begin
                    pend <= 1'b0;
                end
                if (pend) begin
                    recv_cnt <= recv_cnt + 2'd1;
                    unique case (recv_cnt)
                        2'd0: byte_buf[7:0]   <= mem_din;
                        2'd1: byte_buf[15:8]  <= mem_din;
                        2'd2: byte_buf[23:16] <= mem_din;
                        default: begin
                            instr_out   <= {mem_din, byte_buf};
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= IF_HOLD;
                        end
                    endcase
                end
            end else if (instr_valid && !stop) begin
                instr_valid <= 1'b0;
                pc          <= next_pc;
                issue_cnt   <= 3'd0;
                recv_cnt    <= 2'd0;
                pend        <= 1'b0;
                state       <= IF_FETCH;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: scoreboard bench for ifetch with a byte memory model.
// Directed scenarios followed by randomized grant/stop/redirect/rdy traffic.
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        pc_update;
    logic [31:0] pc_address;
    logic        stop;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_grant;
    logic [7:0]  mem_din = 8'h0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    int tests = 0;
    int fails = 0;
    bit jal_mem = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t q[$];

    ifetch #(.RESET_PC(RESET_PC)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .pc_update   (pc_update),
        .pc_address  (pc_address),
        .stop        (stop),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_grant   (mem_grant),
        .mem_din     (mem_din),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte memory: byte[a] = a[7:0], except an optional JAL word at 0x10.
    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] s;
        w = 32'h0080006F;
        if (jal_mem && a >= 32'h10 && a < 32'h14) begin
            s = w >> (8 * (a - 32'h10));
            return s[7:0];
        end
        return a[7:0];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] p);
        return {mem_rd(p + 32'd3), mem_rd(p + 32'd2),
                mem_rd(p + 32'd1), mem_rd(p)};
    endfunction

    function automatic logic [31:0] next_of(input logic [31:0] p,
                                            input logic [31:0] w);
`ifdef IFETCH_JAL_EN
        int off;
        if (w[6:0] == 7'h6F) begin
            off = w[31] ? -(1 << 20) : 0;
            off += int'(w[19:12]) * 4096;
            off += int'(w[20]) * 2048;
            off += int'(w[30:21]) * 2;
            return p + 32'(off);
        end
`else
        if (w[0] === 1'bx) return 32'hx;
`endif
        return p + 32'd4;
    endfunction

    function automatic exp_t mk(input logic [31:0] p);
        return {p, word_at(p)};
    endfunction

    always @(posedge clk_in)
        if (rdy_in && mem_req && mem_grant)
            mem_din <= mem_rd(mem_addr);

    // Reference stream and comparator: reset/redirect restart the expected
    // stream, each accept advances it to the architectural next pc.
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_n_in) begin
            q.delete();
            q.push_back(mk(RESET_PC));
        end else if (rdy_in && pc_update) begin
            q.delete();
            q.push_back(mk(pc_address));
        end else if (instr_valid) begin
            if (q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                chk("instr_pc", instr_pc, q[0].pc);
                chk("instr_out", instr_out, q[0].ins);
                if (rdy_in && !stop) begin
                    e = q.pop_front();
                    q.push_back(mk(next_of(e.pc, e.ins)));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk_in);
            if (instr_valid) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        step();
        rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr", mem_addr, RESET_PC);
        step();
        rst_n_in = 1'b1;
    endtask

    initial begin
        int c;
        int reqs;
        int granted;
        logic [31:0] jal_exp;

        rst_n_in   = 1'b0;
        rdy_in     = 1'b1;
        pc_update  = 1'b0;
        pc_address = 32'h0;
        stop       = 1'b1;
        mem_grant  = 1'b1;

        @(negedge clk_in);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_out", instr_out, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        step();
        step();

        // First fetch: valid in cycle 6, then held by stop.
        rst_n_in = 1'b1;
        wait_valid(20, c);
        chk("latency", 32'(c), 32'd6);
        repeat (10) begin
            @(negedge clk_in);
            chk("stall_req", 32'(mem_req), 32'd0);
        end
        step();
        stop = 1'b0;
        step();
        @(negedge clk_in);
        chk("post_stall_req", 32'(mem_req), 32'd1);
        chk("post_stall_addr", mem_addr, 32'd4);
        // Sampled in cycle 1 already, so valid is 5 negedges later.
        wait_valid(20, c);
        chk("thruput", 32'(c), 32'd5);

        // Alternating grant, starting low in cycle 1.
        stop = 1'b1;
        do_reset();
        reqs = 0;
        granted = 0;
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            mem_grant = (i % 2 == 0);
            @(negedge clk_in);
            if (instr_valid) begin
                c = i;
                break;
            end
            if (mem_req) begin
                reqs++;
                if (mem_grant) begin
                    chk("alt_addr", mem_addr, 32'(granted));
                    granted++;
                end
            end
            @(posedge clk_in);
            #1;
        end
        if (c == 0) chk("alt_timeout", 32'd0, 32'd1);
        chk("alt_reqs", 32'(reqs), 32'd8);
        chk("alt_bytes", 32'(granted), 32'd4);
        step();
        mem_grant = 1'b1;
        stop = 1'b0;
        step();

        // Redirect mid-fetch to 0x100.
        do_reset();
        step();
        step();
        pc_update  = 1'b1;
        pc_address = 32'h100;
        step();
        pc_update = 1'b0;
        @(negedge clk_in);
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_addr", mem_addr, 32'h100);
        wait_valid(20, c);
        chk("redir_pc", instr_pc, 32'h100);
        step();

        // JAL word at 0x10.
        jal_mem = 1'b1;
        pc_update  = 1'b1;
        pc_address = 32'h10;
        step();
        pc_update = 1'b0;
        wait_valid(20, c);
        chk("jal_word", instr_out, 32'h0080006F);
        step();
        @(negedge clk_in);
`ifdef IFETCH_JAL_EN
        jal_exp = 32'h18;
`else
        jal_exp = 32'h14;
`endif
        chk("jal_next_addr", mem_addr, jal_exp);
        step();

        // rdy_in freeze mid-fetch, then reset pulse mid-fetch.
        jal_mem = 1'b0;
        do_reset();
        step();
        step();
        rdy_in = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            chk("frz_req", 32'(mem_req), 32'd0);
            step();
        end
        rdy_in = 1'b1;
        wait_valid(20, c);
        chk("frz_out", instr_out, 32'h03020100);
        step();
        step();
        step();
        rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("rst_mid_valid", 32'(instr_valid), 32'd0);
        chk("rst_mid_addr", mem_addr, RESET_PC);
        step();
        rst_n_in = 1'b1;
        wait_valid(20, c);
        chk("refetch_pc", instr_pc, RESET_PC);
        step();

        // Random traffic, including redirects to the wrap-around boundary.
        for (int i = 0; i < 600; i++) begin
            rdy_in     = ($urandom % 10) != 0;
            mem_grant  = ($urandom % 4) != 0;
            stop       = ($urandom % 3) == 0;
            pc_update  = ($urandom % 25) == 0;
            pc_address = (($urandom % 4) == 0) ? 32'hFFFF_FFFE : $urandom;
            step();
        end
        rdy_in    = 1'b1;
        mem_grant = 1'b1;
        stop      = 1'b0;
        pc_update = 1'b0;
        wait_valid(20, c);
        repeat (15) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
